// File: rtl/data_sync_req_tx_pkg.sv
// data_sync_req_tx_pkg: state encoding and default sizes shared by both ends of the req/ack synchronizer
package data_sync_req_tx_pkg;
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_ACK_HI = 2'b01,
        WAIT_ACK_LO = 2'b10
    } state_t;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_STAGES = 2;
endpackage

// File: rtl/data_sync_req_tx_bit_sync_ff.sv
// bit_sync_ff: multi-flop single-bit synchronizer into the CLK domain
module bit_sync_ff #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [NUM_STAGES-1:0] sr;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sr <= '0;
        else      sr <= {sr[NUM_STAGES-2:0], d};
    end
    assign q = sr[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_req_tx.sv
// data_sync_req_tx: source side of a four-phase req/ack synchronizer; holds a word and drives a request level
module data_sync_req_tx
    import data_sync_req_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SRC_PULSE,
    input  logic [DATA_WIDTH-1:0] SRC_DATA,
    input  logic                  ACK_ASYNC,
    output logic                  REQ_LVL,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DROP_ERR
);
    state_t state;
    logic   ack_s;

    bit_sync_ff #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (ACK_ASYNC),
        .q   (ack_s)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            REQ_LVL  <= 1'b0;
            TX_DATA  <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DROP_ERR <= 1'b0;
        end else begin
            DONE     <= 1'b0;
            // any pulse outside IDLE is discarded, including on the completing edge
            DROP_ERR <= SRC_PULSE && state != IDLE;
            case (state)
                IDLE: if (SRC_PULSE) begin
                    TX_DATA <= SRC_DATA;
                    REQ_LVL <= 1'b1;
                    BUSY    <= 1'b1;
                    state   <= WAIT_ACK_HI;
                end
                WAIT_ACK_HI: if (ack_s) begin
                    REQ_LVL <= 1'b0;
                    state   <= WAIT_ACK_LO;
                end
                WAIT_ACK_LO: if (!ack_s) begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_sync_req_tx.md
Name: data_sync_req_tx

Overview:
Source-side initiator of the four-phase req/ack data synchronizer used for multi-clock-domain crossings. Accepts a one-cycle request pulse with a data word, holds the word stable, and raises a level request (REQ_LVL) toward the destination domain. It waits for the returned acknowledge (synchronized internally) to complete the full four-phase handshake, then reports completion. This is the level-producing counterpart of the destination-side level-to-pulse converter.

Parameters:
DATA_WIDTH, 8, width of transferred data word
NUM_STAGES, 2, flip-flop stages in ACK synchronizer (legal range 2..4)

Ports:
CLK  input  1  source-domain clock
RST  input  1  asynchronous active-low reset
SRC_PULSE  input  1  one-cycle transfer request, synchronous to CLK
SRC_DATA  input  DATA_WIDTH  word sampled when SRC_PULSE accepted
ACK_ASYNC  input  1  acknowledge level from destination domain, asynchronous
REQ_LVL  output  1  request level toward destination, registered
TX_DATA  output  DATA_WIDTH  held data bus, stable while REQ_LVL high, registered
BUSY  output  1  high when a transfer is in progress, registered
DONE  output  1  one-cycle pulse when handshake fully completes
DROP_ERR  output  1  one-cycle pulse when SRC_PULSE arrives while busy

Behaviour:
- Reset (RST low, asynchronous): state IDLE; REQ_LVL=0, TX_DATA=0, BUSY=0, DONE=0, DROP_ERR=0; all synchronizer flops 0.
- ack_s = ACK_ASYNC after NUM_STAGES CLK flops. Only ack_s is used by the FSM. ACK_ASYNC is never used combinationally.
- FSM states: IDLE, WAIT_ACK_HI, WAIT_ACK_LO.
- IDLE:
  - SRC_PULSE=1 accepts the request.
  - On that edge, TX_DATA<=SRC_DATA, REQ_LVL<=1, BUSY<=1, next state WAIT_ACK_HI.
  - REQ_LVL is visible 1 cycle after the accepting pulse.
- WAIT_ACK_HI: ack_s=1 gives REQ_LVL<=0 and next state WAIT_ACK_LO. Otherwise hold.
- WAIT_ACK_LO: ack_s=0 gives BUSY<=0, DONE<=1 for one cycle, and next state IDLE.
- TX_DATA changes only on an accepted request. It is held after completion; it is not cleared.
- A pulse is accepted only in IDLE with BUSY=0. SRC_PULSE in any other state:
  - the pulse is ignored;
  - DROP_ERR is high the following cycle for one cycle;
  - the state and TX_DATA are unaffected.
- Completion cycle: SRC_PULSE sampled on the same edge that moves WAIT_ACK_LO to IDLE is dropped (state not yet IDLE). A pulse on the next edge is accepted.
- Back-to-back throughput: at most one transfer per (2*NUM_STAGES + 2 + destination latency) cycles.
- ack_s=1 while in IDLE (spurious or stale ACK) is ignored. It does not block acceptance.
- SRC_PULSE held high across multiple cycles:
  - the first cycle in IDLE is accepted;
  - each subsequent high cycle while busy produces a DROP_ERR pulse.
- Reset mid-transfer immediately returns to IDLE with REQ_LVL=0. The destination is expected to be reset in the same reset domain.
- DONE and DROP_ERR are mutually independent and may assert in the same cycle.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit: IDLE=2'b00, WAIT_ACK_HI=2'b01, WAIT_ACK_LO=2'b10);
  - default DATA_WIDTH and NUM_STAGES constants, reused by the destination-side block.
- One sub-module: bit_sync_ff. It is a parameterized NUM_STAGES single-bit multi-flop synchronizer with CLK/RST, used for ACK_ASYNC and reusable on the destination side for REQ_LVL.

Test Plan:
- Reset check: assert RST low mid-simulation -> REQ_LVL, BUSY, DONE, DROP_ERR, TX_DATA all 0 asynchronously, without waiting for a CLK edge.
- Single transfer: SRC_DATA=8'hA5 with SRC_PULSE at cycle 0; ACK model raises ACK_ASYNC 3 cycles after seeing REQ_LVL and lowers it 3 cycles after REQ_LVL falls. Required response:
  - REQ_LVL=1 from cycle 1;
  - TX_DATA=8'hA5 from cycle 1;
  - REQ_LVL falls NUM_STAGES cycles after ACK rises;
  - DONE pulses once, NUM_STAGES cycles after ACK falls;
  - BUSY falls together with DONE.
- Drop while busy: SRC_PULSE with 8'h3C during WAIT_ACK_HI -> DROP_ERR one-cycle pulse, TX_DATA stays 8'hA5, exactly one DONE.
- Completion-edge race:
  - pulse on the WAIT_ACK_LO->IDLE edge -> DROP_ERR;
  - pulse 1 cycle later with 8'h5A -> accepted, TX_DATA=8'h5A.
- Stale ACK: ACK_ASYNC=1 in IDLE, then SRC_PULSE with 8'h11 -> accepted. FSM waits in WAIT_ACK_HI until the first ack_s=1, then in WAIT_ACK_LO until ack_s returns 0; exactly one DONE.
- Reset mid-transfer: RST low during WAIT_ACK_LO -> IDLE, BUSY=0, no DONE. After release, a new pulse with 8'hFF completes normally.
